// File: rtl/card_flip_ctrl_pkg.sv
// card_flip_ctrl_pkg: shared state encoding and default board dimensions for the memory-game controller
package card_flip_ctrl_pkg;
    localparam int N_CARDS_DEF     = 16;
    localparam int IDX_W_DEF       = 4;
    localparam int VAL_W_DEF       = 3;
    localparam int HOLD_FRAMES_DEF = 60;
    typedef enum logic [2:0] {WAIT_FIRST, WAIT_SECOND, HOLD, RESOLVE, DONE} state_t;
endpackage

// File: rtl/card_flip_ctrl_if.sv
// card_flip_ctrl_if: card pick handshake between the click decoder (master) and the controller (slave)
interface card_flip_ctrl_if #(parameter int IDX_W = 4) ();
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_ready;
    logic             pick_err;
    modport master (output pick_valid, pick_idx, input pick_ready, pick_err);
    modport slave (input pick_valid, pick_idx, output pick_ready, pick_err);
endinterface

// File: rtl/card_flip_ctrl_frame_sync_timer.sv
// card_flip_ctrl_frame_sync_timer: vblank rising-edge detector plus a clearable frame counter with terminal-count flag
module card_flip_ctrl_frame_sync_timer #(parameter int CNT_W = 8) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             vblnk,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             fstart,
    output logic             tc
);
    logic             vblnk_d;
    logic [CNT_W-1:0] cnt;
    assign fstart = vblnk & ~vblnk_d;
    assign tc     = cnt == term;
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            vblnk_d <= 1'b0;
            cnt     <= '0;
        end else begin
            vblnk_d <= vblnk;
            cnt     <= clr ? '0 : (en & fstart) ? cnt + 1'b1 : cnt;
        end
    end
endmodule

// File: rtl/card_flip_ctrl.sv
// card_flip_ctrl: memory-game pick/hold/resolve sequencer driving frame-synced card overlay enables
module card_flip_ctrl
    import card_flip_ctrl_pkg::*;
#(
    parameter int N_CARDS     = N_CARDS_DEF,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int VAL_W       = VAL_W_DEF,
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
    input  logic                     pclk,
    input  logic                     rst,
    input  logic                     vblnk,
    input  logic                     new_game,
    input  logic [N_CARDS*VAL_W-1:0] card_values,
    card_flip_ctrl_if.slave          pick,
    output logic [N_CARDS-1:0]       face_en,
    output logic [N_CARDS-1:0]       matched_en,
    output logic                     match_pulse,
    output logic                     mismatch_pulse,
    output logic [IDX_W-1:0]         pairs_found,
    output logic                     game_done
);
    state_t             state, state_nx;
    logic [N_CARDS-1:0] up, matched, sel, pair;
    logic [IDX_W-1:0]   first, second;
    logic               eq, fstart, tc, in_range, attempt, accept, hold_clr;

    function automatic logic [VAL_W-1:0] val(input logic [IDX_W-1:0] i);
        return VAL_W'(card_values >> (32'(i) * VAL_W));
    endfunction

    // one-hot decode by shifting so out-of-range indices simply select nothing
    assign sel             = N_CARDS'(1) << pick.pick_idx;
    assign pair            = (N_CARDS'(1) << first) | (N_CARDS'(1) << second);
    assign in_range        = 32'(pick.pick_idx) < N_CARDS;
    assign pick.pick_ready = rst & (state == WAIT_FIRST || state == WAIT_SECOND);
    assign attempt         = pick.pick_valid & pick.pick_ready & ~new_game;
    assign accept          = attempt & in_range & ~|((up | matched) & sel);
    assign hold_clr        = new_game | (state == WAIT_SECOND & accept);
    assign game_done       = state == DONE;

    card_flip_ctrl_frame_sync_timer #(.CNT_W(8)) u_timer (
        .pclk   (pclk),
        .rst    (rst),
        .vblnk  (vblnk),
        .clr    (hold_clr),
        .en     (state == HOLD),
        .term   (8'(HOLD_FRAMES - 1)),
        .fstart (fstart),
        .tc     (tc)
    );

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) state <= WAIT_FIRST;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (new_game) state_nx = WAIT_FIRST;
        else case (state)
            WAIT_FIRST:  state_nx = accept ? WAIT_SECOND : WAIT_FIRST;
            WAIT_SECOND: state_nx = accept ? HOLD : WAIT_SECOND;
            HOLD:        state_nx = (fstart & tc) ? RESOLVE : HOLD;
            RESOLVE:     state_nx = (eq && pairs_found == IDX_W'(N_CARDS / 2 - 1)) ? DONE : WAIT_FIRST;
            DONE:        state_nx = DONE;
            default:     state_nx = WAIT_FIRST;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            up             <= '0;
            matched        <= '0;
            first          <= '0;
            second         <= '0;
            eq             <= 1'b0;
            pairs_found    <= '0;
            match_pulse    <= 1'b0;
            mismatch_pulse <= 1'b0;
            pick.pick_err  <= 1'b0;
            face_en        <= '0;
            matched_en     <= '0;
        end else begin
            match_pulse    <= 1'b0;
            mismatch_pulse <= 1'b0;
            pick.pick_err  <= attempt & ~accept;
            if (fstart) begin
                face_en    <= up | matched;
                matched_en <= matched;
            end
            if (new_game) begin
                up          <= '0;
                matched     <= '0;
                pairs_found <= '0;
            end else if (accept) begin
                up <= up | sel;
                if (state == WAIT_FIRST) first <= pick.pick_idx;
                else begin
                    second <= pick.pick_idx;
                    eq     <= val(first) == val(pick.pick_idx);
                end
            end else if (state == RESOLVE) begin
                up <= up & ~pair;
                if (eq) begin
                    matched     <= matched | pair;
                    pairs_found <= pairs_found + 1'b1;
                    match_pulse <= 1'b1;
                end else mismatch_pulse <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_card_flip_ctrl.sv
// tb_card_flip_ctrl: directed and randomized picks checked against a board-level model of the memory game
module tb_card_flip_ctrl;
    localparam int NC = 16, IW = 5, VW = 3, HF = 2;
    logic pclk = 0, rst = 1, vblnk = 0, new_game = 0;
    logic [NC*VW-1:0] card_values = '0;
    logic [NC-1:0] face_en, matched_en;
    logic match_pulse, mismatch_pulse, game_done;
    logic [IW-1:0] pairs_found;
    int checks = 0, failures = 0;
    int vals[NC];
    bit m_up[NC], m_mat[NC], m_done;
    int m_pairs, m_first, m_second, hold;
    logic [NC-1:0] exp_face, exp_mat;
    int exp_match = 0, exp_mis = 0, exp_err = 0, seen_match = 0, seen_mis = 0, seen_err = 0;

    card_flip_ctrl_if #(.IDX_W(IW)) pif ();
    card_flip_ctrl #(.N_CARDS(NC), .IDX_W(IW), .VAL_W(VW), .HOLD_FRAMES(HF)) dut (
        .pclk(pclk), .rst(rst), .vblnk(vblnk), .new_game(new_game), .card_values(card_values),
        .pick(pif), .face_en(face_en), .matched_en(matched_en), .match_pulse(match_pulse),
        .mismatch_pulse(mismatch_pulse), .pairs_found(pairs_found), .game_done(game_done)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (match_pulse === 1'b1) seen_match++;
        if (mismatch_pulse === 1'b1) seen_mis++;
        if (pif.pick_err === 1'b1) seen_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NC-1:0] board_vec(input bit only_matched);
        logic [NC-1:0] b;
        b = '0;
        for (int i = 0; i < NC; i++) b[i] = m_mat[i] | (m_up[i] & !only_matched);
        return b;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NC; i++) begin
            m_up[i] = 0;
            m_mat[i] = 0;
        end
        m_pairs = 0; m_first = -1; m_second = -1; hold = -1; m_done = 0;
    endtask

    function automatic int partner(input int a);
        for (int j = 0; j < NC; j++) if (j != a && vals[j] == vals[a]) return j;
        return a;
    endfunction

    function automatic int rand_free(input int excl);
        int q[$];
        for (int i = 0; i < NC; i++) if (!m_mat[i] && i != excl) q.push_back(i);
        return q[$urandom_range(0, q.size() - 1)];
    endfunction

    task automatic resolve();
        if (vals[m_first] == vals[m_second]) begin
            m_mat[m_first] = 1;
            m_mat[m_second] = 1;
            m_pairs++;
            exp_match++;
            m_done = m_pairs == NC / 2;
        end else exp_mis++;
        m_up[m_first] = 0;
        m_up[m_second] = 0;
        m_first = -1;
        hold = -1;
    endtask

    task automatic frame();
        logic [NC-1:0] f, m;
        f = board_vec(0);
        m = board_vec(1);
        vblnk = 1;
        repeat (3) @(negedge pclk);
        vblnk = 0;
        repeat (5) @(negedge pclk);
        exp_face = f;
        exp_mat = m;
        if (hold >= 0) begin
            hold++;
            if (hold == HF) resolve();
        end
        chk("face_en", 32'(face_en), 32'(exp_face));
        chk("matched_en", 32'(matched_en), 32'(exp_mat));
        chk("pairs_found", 32'(pairs_found), 32'(m_pairs));
        chk("game_done", 32'(game_done), 32'(m_done));
        chk("match_count", 32'(seen_match), 32'(exp_match));
        chk("mismatch_count", 32'(seen_mis), 32'(exp_mis));
    endtask

    task automatic pick(input int idx);
        bit rdy;
        rdy = !m_done && hold < 0;
        chk("pick_ready", 32'(pif.pick_ready), 32'(rdy));
        pif.pick_valid = 1;
        pif.pick_idx = IW'(idx);
        @(negedge pclk);
        pif.pick_valid = 0;
        if (rdy) begin
            if (idx >= NC || m_up[idx] || m_mat[idx]) exp_err++;
            else begin
                m_up[idx] = 1;
                if (m_first < 0) m_first = idx;
                else begin
                    m_second = idx;
                    hold = 0;
                end
            end
        end
        @(negedge pclk);
        chk("pick_err_count", 32'(seen_err), 32'(exp_err));
    endtask

    task automatic start_new(input bit with_pick, input int idx);
        new_game = 1;
        pif.pick_valid = with_pick;
        pif.pick_idx = IW'(idx);
        @(negedge pclk);
        new_game = 0;
        pif.pick_valid = 0;
        clear_model();
        @(negedge pclk);
        chk("ng_ready", 32'(pif.pick_ready), 32'd1);
        chk("ng_game_done", 32'(game_done), 32'd0);
        chk("ng_pairs", 32'(pairs_found), 32'd0);
        chk("ng_err_count", 32'(seen_err), 32'(exp_err));
        chk("ng_face_held", 32'(face_en), 32'(exp_face));
    endtask

    initial begin
        int pool[$] = '{1, 4, 2, 2, 3, 3, 5, 5, 6, 6, 7, 7};
        for (int i = pool.size() - 1; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = pool[i];
            pool[i] = pool[j];
            pool[j] = t;
        end
        for (int i = 0; i < NC; i++) begin
            vals[i] = (i == 3 || i == 7) ? 0 : (i == 1) ? 1 : (i == 2) ? 4 : pool.pop_front();
            card_values[i*VW +: VW] = VW'(vals[i]);
        end
        clear_model();
        exp_face = '0;
        exp_mat = '0;
        pif.pick_valid = 0;
        pif.pick_idx = '0;
        #1 rst = 0;
        repeat (2) @(negedge pclk);
        chk("rst_face", 32'(face_en), 32'd0);
        chk("rst_matched", 32'(matched_en), 32'd0);
        chk("rst_pairs", 32'(pairs_found), 32'd0);
        chk("rst_ready", 32'(pif.pick_ready), 32'd0);
        chk("rst_done", 32'(game_done), 32'd0);
        rst = 1;
        #1 chk("ready_after_release", 32'(pif.pick_ready), 32'd1);
        @(negedge pclk);
        frame();
        frame();
        pick(3);
        pick(7);
        chk("face_before_fstart", 32'(face_en), 32'd0);
        repeat (3) frame();
        pick(1);
        pick(2);
        repeat (3) frame();
        pick(3);
        pick(0);
        pick(0);
        pick(16);
        pick(5);
        pick(6);
        repeat (3) frame();
        for (int r = 0; r < 40 && m_pairs < NC / 2; r++) begin
            int a, b;
            if ($urandom_range(0, 3) == 0) pick(int'($urandom_range(16, 31)));
            a = rand_free(-1);
            b = (r >= 16 || $urandom_range(0, 1) == 1) ? partner(a) : rand_free(a);
            pick(a);
            if ($urandom_range(0, 4) == 0) pick(a);
            pick(b);
            repeat (HF + 1) frame();
        end
        chk("all_done", 32'(game_done), 32'd1);
        chk("done_ready", 32'(pif.pick_ready), 32'd0);
        pick(4);
        start_new(0, 0);
        frame();
        pick(3);
        pick(7);
        frame();
        start_new(1, 9);
        repeat (HF + 1) frame();
        pick(1);
        pick(3);
        frame();
        @(negedge pclk);
        #2 rst = 0;
        #1;
        chk("async_face", 32'(face_en), 32'd0);
        chk("async_matched", 32'(matched_en), 32'd0);
        chk("async_ready", 32'(pif.pick_ready), 32'd0);
        chk("async_pairs", 32'(pairs_found), 32'd0);
        clear_model();
        repeat (3) @(negedge pclk);
        rst = 1;
        repeat (HF + 1) frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/card_flip_ctrl.md
Name: card_flip_ctrl

Overview:
Game-level controller that sequences the per-card rectangle overlays of the memory game. It accepts card picks from the mouse/click decoder, tracks face-up and matched cards, and holds a revealed pair for a programmable number of frames. It then resolves the pair as a match or a mismatch. Its enable vectors drive the bank of rectangle-drawing stages in the VGA pipeline and are updated only at vertical-blank start, so no frame ever shows a half-applied change.

Parameters:
N_CARDS, 16, number of cards; must be even.
IDX_W, 4, card index width; 2^IDX_W >= N_CARDS.
VAL_W, 3, card face value width; N_CARDS/2 distinct values.
HOLD_FRAMES, 60, frames a revealed pair stays visible before resolution; legal range 1..255.

Ports:
pclk  in  1  pixel clock; the only clock.
rst  in  1  asynchronous, active-low reset.
vblnk  in  1  vertical blank from the timing generator, pclk-synchronous.
new_game  in  1  one-cycle pulse: clear the board and restart.
card_values  in  N_CARDS*VAL_W  packed face value per card; card i at [i*VAL_W +: VAL_W]; static during a game.
pick_valid  in  1  pick request strobe.
pick_idx  in  IDX_W  index of the picked card.
pick_ready  out  1  controller accepts picks.
pick_err  out  1  one-cycle pulse: pick rejected.
face_en  out  N_CARDS  frame-synced enable for the "face shown" rectangle of each card.
matched_en  out  N_CARDS  frame-synced enable for the "matched" highlight of each card.
match_pulse  out  1  one-cycle pulse when a pair resolves as a match.
mismatch_pulse  out  1  one-cycle pulse when a pair resolves as a mismatch.
pairs_found  out  IDX_W  number of matched pairs.
game_done  out  1  all pairs matched.

Behaviour:
- Reset (rst=0, async): state WAIT_FIRST. All internal up/matched bits, face_en, matched_en, pairs_found, pulses, game_done, frame counter and first/second index registers = 0. pick_ready=0 while rst=0 and 1 in the first cycle after release.
- Internal vectors: up[N_CARDS] (currently revealed, unmatched) and matched[N_CARDS].
- Frame edge: vblnk is registered once; fstart = vblnk & ~vblnk_d.
- On fstart: face_en <= up | matched and matched_en <= matched. Outputs change only on these cycles. Latency from an internal change to the outputs is at most one frame plus one cycle.
- pick_ready = 1 in WAIT_FIRST and WAIT_SECOND only.
- A pick is accepted when pick_valid & pick_ready & pick_idx < N_CARDS & !up[idx] & !matched[idx].
- pick_valid & pick_ready with any other condition gives a pick_err pulse (registered, next cycle) and no state change.
- pick_valid while pick_ready=0 is ignored silently.
- State WAIT_FIRST: on an accepted pick, set up[idx], store idx as first, go to WAIT_SECOND.
- State WAIT_SECOND: on an accepted pick, set up[idx], store second, register eq = (value[first] == value[second]), clear the frame counter, go to HOLD.
- State HOLD: the counter increments on each fstart. When counter == HOLD_FRAMES-1 and fstart occurs, go to RESOLVE. The pair is therefore displayed for exactly HOLD_FRAMES full frames.
- State RESOLVE (one cycle), match case (eq=1): set matched[first] and matched[second], clear their up bits, pulse match_pulse, pairs_found += 1.
- State RESOLVE, mismatch case: clear up[first] and up[second], pulse mismatch_pulse.
- RESOLVE exit: go to DONE if pairs_found (post-increment) == N_CARDS/2, else WAIT_FIRST.
- State DONE: game_done=1, pick_ready=0; it stays until new_game.
- new_game, any state including HOLD: next cycle, state WAIT_FIRST, up=matched=0, pairs_found=0, game_done=0, counter=0. Display outputs clear at the next fstart. new_game wins over a simultaneous pick (no pick_err).
- A pick and fstart in the same cycle are both processed.
- pairs_found never exceeds N_CARDS/2; no wrap.
- Reset asserted mid-HOLD aborts immediately; no resolve pulse is emitted.

Decomposition:
- Shared package/header: state encoding localparams (WAIT_FIRST, WAIT_SECOND, HOLD, RESOLVE, DONE) and the default card-count and value-width constants.
- Natural sub-module: frame_sync_timer. It contains the vblnk edge detector plus a frame counter with clear and terminal-count output, and is reusable by other frame-timed effects.

Test Plan:
- Reset release, vblnk toggling, no picks -> face_en=matched_en=0, pick_ready=1, pairs_found=0.
- Values 0,0 at cards 3,7; pick 3 then 7, HOLD_FRAMES=2 -> face_en bits 3,7 set at the next fstart. match_pulse fires after 2 fstarts. matched_en[3], matched_en[7]=1 at the following fstart. pairs_found=1.
- Cards 1,2 with values 1,4; pick 1, then 2 -> both shown for 2 frames. Then mismatch_pulse fires and face_en bits 1,2 clear at the following fstart; pairs_found unchanged.
- Pick card 3 after it is matched, pick the same index twice, pick idx 16 with N_CARDS=16 -> pick_err pulse each time, state unchanged. A pick during HOLD -> no pick_err, ignored.
- Match all 8 pairs -> game_done=1 after the 8th RESOLVE, pick_ready=0. new_game -> all outputs clear by the next fstart, pick_ready=1.
- new_game asserted during HOLD together with pick_valid -> no match/mismatch pulse, no pick_err, board cleared. Then assert async reset mid-frame -> outputs 0 immediately, without waiting for a pclk edge.
